encoder_pt2262: RTL and testbench
=================================

ENCODER_PT2262 -- requirements
Module: encoder_pt2262

Interface
REQ-001 SHALL have port osc_clk, input, 1, encoder time base; one cycle = one alpha (a) unit.
REQ-002 SHALL have port reset, input, 1, reset, asynchronous, active-high.
REQ-003 SHALL have port te, input, 1, transmit enable, active-high, sampled on osc_clk.
REQ-004 SHALL have port A, input, 16, trinary address, 2 bits per pin, pin k = A[2k+1:2k]; 2'b00=0, 2'b11=1, 2'b10=F, 2'b01 treated as F.
REQ-005 SHALL have port D, input, 4, binary data, transmitted as pins 8..11 = D[3], D[2], D[1], D[0].
REQ-006 SHALL have port cod_o, output, 1, registered serial PT2262 waveform.
REQ-007 SHALL have port tx_active, output, 1, high while a word is being transmitted.
REQ-008 SHALL have port word_done, output, 1, one-cycle pulse on the last cycle of each word's sync.

Function
REQ-009 SHALL implement FSM states IDLE, BIT, SYNC; IDLE->BIT when te=1 sampled; BIT->SYNC after pin 11; SYNC->BIT (next word) or ->IDLE at word end.
REQ-010 SHALL latch A and D into internal registers at the start of every word; input changes during a word SHALL NOT affect that word.
REQ-011 SHALL transmit pins in order 0..11 (A pin0..pin7, then D[3]..D[0]), each pin exactly 32 cycles.
REQ-012 SHALL encode bit 0 as 4a high, 12a low, 4a high, 12a low.
REQ-013 SHALL encode bit 1 as 12a high, 4a low, 12a high, 4a low.
REQ-014 SHALL encode bit F as 4a high, 12a low, 12a high, 4a low.
REQ-015 SHALL encode sync as 4a high, 124a low (128 cycles); one word = 512 cycles exactly.
REQ-016 SHALL drive cod_o high on the first cycle after the edge at which te is sampled high in IDLE (latency 1).
REQ-017 SHALL start the next word on the cycle immediately after word_done with no gap when continuing.
REQ-018 SHALL, if te is deasserted mid-word, complete the current word including sync before deciding to stop.
REQ-019 SHALL, at word end with te=0 and no minimum-word obligation pending, go to IDLE with cod_o=0, tx_active=0.
REQ-020 SHALL hold tx_active=1 from the first high chip of a word to the last sync cycle inclusive.
REQ-021 SHALL use a 5-bit chip counter (wraps 31->0 per pin), 4-bit pin index (0..11), 7-bit sync counter (0..127); no other wrap values permitted.
REQ-022 SHALL keep cod_o=0 in IDLE.

Reset
REQ-023 SHALL on reset assertion immediately force cod_o=0, tx_active=0, word_done=0, state IDLE, all counters 0, latched A/D = 0.
REQ-024 SHALL on reset mid-word abort the word with no further output; after release, require te sampled high to start again.
REQ-025 SHALL, if te=1 at reset release, start a new word on the first osc_clk edge after release.

Configuration
REQ-026 SHALL support macro ENCODER_PT2262_MIN_WORDS_EN.
REQ-027 With ENCODER_PT2262_MIN_WORDS_EN defined: each te activation from IDLE SHALL produce at least 4 complete words, even if te drops earlier; more words while te stays high.
REQ-028 Without ENCODER_PT2262_MIN_WORDS_EN: words SHALL be sent only while te=1 at word end; minimum one word per activation; no word counter synthesized.

Verification
REQ-029 te=1 one cycle, A=16'h0000, D=4'h0, macro off -> one 512-cycle word, all pins 4H/12L/4H/12L, sync 4H/124L, one word_done, then IDLE.
REQ-030 te held high, A=16'hFFFF, D=4'hF -> continuous words of bit-1 pattern, word_done every 512 cycles, no gap between words.
REQ-031 A pin0=2'b10, pin1=2'b01, rest 2'b00, D=4'b1000 -> pins 0,1 F pattern, pin 8 bit-1 pattern, pins 9..11 bit-0 pattern.
REQ-032 macro on, te pulse one cycle -> exactly 4 words (2048 cycles), 4 word_done pulses, then cod_o=0.
REQ-033 reset asserted at cycle 100 of a word -> cod_o=0 and tx_active=0 same cycle, no word_done; after release with te=0 stays IDLE.
REQ-034 change A and D at cycle 200 of word 1 with te held -> word 1 unchanged, word 2 carries new values.

Source files
------------

// File: rtl/encoder_pt2262.sv
// PT2262-style trinary remote-control encoder: 12 pins of 32 chips each plus a 128-chip sync.
// Optional ENCODER_PT2262_MIN_WORDS_EN: every activation from IDLE sends at least 4 words.
module encoder_pt2262 (
    input  logic        osc_clk,
    input  logic        reset,
    input  logic        te,
    input  logic [15:0] A,
    input  logic [3:0]  D,
    output logic        cod_o,
    output logic        tx_active,
    output logic        word_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BIT  = 2'd1,
        SYNC = 2'd2
    } state_t;

    localparam logic [3:0] LAST_PIN  = 4'd11;
    localparam logic [4:0] LAST_CHIP = 5'd31;
    localparam logic [6:0] LAST_SYNC = 7'd127;

    state_t      state, state_next;
    logic [3:0]  pin, pin_next;
    logic [4:0]  chip, chip_next;
    logic [6:0]  sync_cnt, sync_next;
    logic [15:0] addr_q, addr_next;
    logic [3:0]  data_q, data_next;
    logic        word_end;
    logic        keep_going;
    logic        start_word;

    assign word_end = (state == SYNC) && (sync_cnt == LAST_SYNC);

`ifdef ENCODER_PT2262_MIN_WORDS_EN
    // Words completed in the current activation, saturating at 3.
    logic [1:0] word_cnt;

    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) begin
            word_cnt <= 2'd0;
        end else if (state == IDLE) begin
            word_cnt <= 2'd0;
        end else if (word_end && (word_cnt != 2'd3)) begin
            word_cnt <= word_cnt + 2'd1;
        end
    end

    assign keep_going = te || (word_cnt != 2'd3);
`else
    assign keep_going = te;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pin      <= 4'd0;
            chip     <= 5'd0;
            sync_cnt <= 7'd0;
            addr_q   <= 16'd0;
            data_q   <= 4'd0;
        end else begin
            state    <= state_next;
            pin      <= pin_next;
            chip     <= chip_next;
            sync_cnt <= sync_next;
            addr_q   <= addr_next;
            data_q   <= data_next;
        end
    end

    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_next = state;
        pin_next   = pin;
        chip_next  = chip;
        sync_next  = sync_cnt;
        addr_next  = addr_q;
        data_next  = data_q;
        start_word = 1'b0;
        case (state)
            IDLE: begin
                if (te) begin
                    state_next = BIT;
                    start_word = 1'b1;
                end
            end
            BIT: begin
                chip_next = chip + 5'd1;
                if (chip == LAST_CHIP) begin
                    if (pin == LAST_PIN) begin
                        state_next = SYNC;
                        pin_next   = 4'd0;
                        sync_next  = 7'd0;
                    end else begin
                        pin_next = pin + 4'd1;
                    end
                end
            end
            SYNC: begin
                sync_next = sync_cnt + 7'd1;
                if (word_end) begin
                    if (keep_going) begin
                        state_next = BIT;
                        start_word = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // The word's symbols are frozen here, so later input changes only affect the next word.
        if (start_word) begin
            addr_next = A;
            data_next = D;
            pin_next  = 4'd0;
            chip_next = 5'd0;
        end
    end

    logic [1:0] pair;
    logic [1:0] data_idx;
    logic       sym_one;
    logic       sym_zero;
    logic       cod_next;
    logic       tx_next;
    logic       done_next;

    // Outputs are decoded from the next-cycle position and then registered.
    always_comb begin
        pair     = addr_next[{pin_next[2:0], 1'b0} +: 2];
        data_idx = ~pin_next[1:0];
        if (pin_next[3]) begin
            sym_one  = data_next[data_idx];
            sym_zero = ~data_next[data_idx];
        end else begin
            sym_one  = (pair == 2'b11);
            sym_zero = (pair == 2'b00);
        end
        // First half-pin is long only for bit 1; second half is short only for bit 0.
        case (state_next)
            BIT: begin
                if (chip_next[4]) begin
                    cod_next = chip_next[3:0] < (sym_zero ? 4'd4 : 4'd12);
                end else begin
                    cod_next = chip_next[3:0] < (sym_one ? 4'd12 : 4'd4);
                end
            end
            SYNC:    cod_next = sync_next < 7'd4;
            default: cod_next = 1'b0;
        endcase
        tx_next   = state_next != IDLE;
        done_next = (state_next == SYNC) && (sync_next == LAST_SYNC);
    end

    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) begin
            cod_o     <= 1'b0;
            tx_active <= 1'b0;
            word_done <= 1'b0;
        end else begin
            cod_o     <= cod_next;
            tx_active <= tx_next;
            word_done <= done_next;
        end
    end

endmodule

// File: tb/tb_encoder_pt2262.sv
// Self-checking bench for encoder_pt2262: word-level waveform model, directed and random stimulus.
module tb_encoder_pt2262;

`ifdef ENCODER_PT2262_MIN_WORDS_EN
    localparam int MIN_WORDS = 4;
`else
    localparam int MIN_WORDS = 1;
`endif
    localparam int TWO_WORDS = (MIN_WORDS > 2) ? MIN_WORDS : 2;

    logic        osc_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        te      = 1'b0;
    logic [15:0] A       = 16'h0000;
    logic [3:0]  D       = 4'h0;
    logic        cod_o;
    logic        tx_active;
    logic        word_done;

    int n_cmp = 0;
    int n_bad = 0;

    encoder_pt2262 dut (
        .osc_clk   (osc_clk),
        .reset     (reset),
        .te        (te),
        .A         (A),
        .D         (D),
        .cod_o     (cod_o),
        .tx_active (tx_active),
        .word_done (word_done)
    );

    always #5 osc_clk = ~osc_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word is a 512-entry waveform built from run lengths.
    bit wave [512];
    int pos   = -1;
    int words = 0;
    bit exp_cod, exp_tx, exp_done;

    // Run lengths H,L,H,L for symbols 0, 1, F.
    int runs [3][4] = '{'{4, 12, 4, 12}, '{12, 4, 12, 4}, '{4, 12, 12, 4}};

    task automatic build_word(input logic [15:0] a, input logic [3:0] d);
        int n;
        int sym;
        logic [1:0] pr;
        n = 0;
        for (int p = 0; p < 12; p++) begin
            if (p < 8) begin
                pr  = a[2*p +: 2];
                sym = (pr == 2'b00) ? 0 : (pr == 2'b11) ? 1 : 2;
            end else begin
                sym = d[11 - p] ? 1 : 0;
            end
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < runs[sym][r]; c++) begin
                    wave[n] = (r % 2 == 0);
                    n++;
                end
        end
        for (int c = 0; c < 128; c++) begin
            wave[n] = (c < 4);
            n++;
        end
    endtask

    always @(posedge osc_clk or posedge reset) begin
        if (reset) begin
            pos = -1;
        end else if (pos < 0) begin
            if (te) begin
                words = 0;
                build_word(A, D);
                pos = 0;
            end
        end else begin
            pos++;
            if (pos == 512) begin
                words++;
                if (te || words < MIN_WORDS) begin
                    build_word(A, D);
                    pos = 0;
                end else begin
                    pos = -1;
                end
            end
        end
        exp_cod  = (pos >= 0) ? wave[pos] : 1'b0;
        exp_tx   = (pos >= 0);
        exp_done = (pos == 511);
    end

    int cnt_exp_high = 0;
    int cnt_dut_high = 0;
    int cnt_done     = 0;
    int cnt_tx       = 0;

    // Compare process: every cycle out of reset the outputs must match the model.
    always @(negedge osc_clk) begin
        if (!reset) begin
            check("cod_o", 32'(cod_o), 32'(exp_cod));
            check("tx_active", 32'(tx_active), 32'(exp_tx));
            check("word_done", 32'(word_done), 32'(exp_done));
            cnt_exp_high += int'(exp_cod);
            cnt_dut_high += int'(cod_o);
            cnt_done     += int'(word_done);
            cnt_tx       += int'(tx_active);
        end
    end

    task automatic clear_counts();
        @(posedge osc_clk);
        #1;
        cnt_exp_high = 0;
        cnt_dut_high = 0;
        cnt_done     = 0;
        cnt_tx       = 0;
    endtask

    task automatic pulse_te(input logic [15:0] a, input logic [3:0] d);
        @(negedge osc_clk);
        A  = a;
        D  = d;
        te = 1'b1;
        @(negedge osc_clk);
        te = 1'b0;
    endtask

    task automatic check_counts(input string tag, input int highs, input int dones, input int txs);
        check({tag, "_model_highs"}, 32'(cnt_exp_high), 32'(highs));
        check({tag, "_dut_highs"}, 32'(cnt_dut_high), 32'(highs));
        check({tag, "_done_pulses"}, 32'(cnt_done), 32'(dones));
        check({tag, "_tx_cycles"}, 32'(cnt_tx), 32'(txs));
    endtask

    initial begin
        int on_len;
        int split;

        // Reset state while reset is held.
        @(posedge osc_clk);
        #1;
        check("rst_cod", 32'(cod_o), 32'd0);
        check("rst_tx", 32'(tx_active), 32'd0);
        check("rst_done", 32'(word_done), 32'd0);
        @(negedge osc_clk);
        reset = 1'b0;
        repeat (5) @(negedge osc_clk);

        // All-zero word from a one-cycle te pulse.
        clear_counts();
        pulse_te(16'h0000, 4'h0);
        repeat (2100) @(negedge osc_clk);
        check_counts("zero", 100 * MIN_WORDS, MIN_WORDS, 512 * MIN_WORDS);

        // Mixed symbols: F, F (2'b01), zeros, then D=1000.
        clear_counts();
        pulse_te(16'h0006, 4'b1000);
        repeat (2100) @(negedge osc_clk);
        check_counts("mixed", 132 * MIN_WORDS, MIN_WORDS, 512 * MIN_WORDS);

        // All-one words back to back, te dropped during the second word_done cycle.
        clear_counts();
        @(negedge osc_clk);
        A  = 16'hFFFF;
        D  = 4'hF;
        te = 1'b1;
        repeat (1024) @(negedge osc_clk);
        te = 1'b0;
        repeat (2100) @(negedge osc_clk);
        check_counts("ones", 292 * TWO_WORDS, TWO_WORDS, 512 * TWO_WORDS);

        // Inputs changed at cycle 200 of word 1 with te held.
        @(negedge osc_clk);
        A  = 16'h5A3C;
        D  = 4'h9;
        te = 1'b1;
        repeat (201) @(negedge osc_clk);
        A  = 16'hC30F;
        D  = 4'h6;
        repeat (823) @(negedge osc_clk);
        te = 1'b0;
        repeat (2100) @(negedge osc_clk);

        // Reset at cycle 100 of a word.
        clear_counts();
        @(negedge osc_clk);
        A  = 16'h0000;
        D  = 4'h0;
        te = 1'b1;
        @(posedge osc_clk);
        #1;
        te = 1'b0;
        repeat (100) @(posedge osc_clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_cod", 32'(cod_o), 32'd0);
        check("midrst_tx", 32'(tx_active), 32'd0);
        check("midrst_done", 32'(word_done), 32'd0);
        @(negedge osc_clk);
        reset = 1'b0;
        repeat (600) @(negedge osc_clk);
        check("midrst_done_pulses", 32'(cnt_done), 32'd0);
        check("midrst_tx_cycles", 32'(cnt_tx), 32'd100);

        // te already high at reset release starts a word on the first edge.
        @(posedge osc_clk);
        #2;
        reset = 1'b1;
        te    = 1'b1;
        @(negedge osc_clk);
        reset = 1'b0;
        @(negedge osc_clk);
        check("release_te_cod", 32'(cod_o), 32'd1);
        check("release_te_tx", 32'(tx_active), 32'd1);
        te = 1'b0;
        repeat (2100) @(negedge osc_clk);

        // Randomized activations, mid-word input changes and occasional resets.
        for (int it = 0; it < 30; it++) begin
            @(negedge osc_clk);
            A      = 16'($urandom);
            D      = 4'($urandom);
            te     = 1'b1;
            on_len = int'($urandom_range(1, 1200));
            split  = int'($urandom_range(0, on_len - 1));
            repeat (split) @(negedge osc_clk);
            A = 16'($urandom);
            D = 4'($urandom);
            repeat (on_len - split) @(negedge osc_clk);
            te = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                @(posedge osc_clk);
                #2;
                reset = 1'b1;
                @(negedge osc_clk);
                reset = 1'b0;
            end
            repeat ($urandom_range(1, 600)) @(negedge osc_clk);
        end
        repeat (2100) @(negedge osc_clk);
        check("final_idle_tx", 32'(tx_active), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
